conv_window_ctrl: RTL and testbench

Sequencing controller for the K×K line-buffer window generator (fifo3x3 / fifo5x5 style `read`/`width`/`reset_n` interface).
- Accepts a frame request, latches and validates the frame dimensions, and holds the window generator in reset while its size register loads.
- Gates the pixel stream into it and tracks column and row of every accepted pixel.
- Flags only the windows that lie fully inside the image, with coordinates and frame markers.
- Sits between the pixel source (camera/DMA stream) and the window generator plus convolution kernel.

---
 rtl/conv_window_ctrl_if.sv | 57 +++++
 rtl/conv_window_ctrl.sv | 169 ++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_ctrl_if.sv
// ---------------------------------------------------------------------------
// conv_window_ctrl_if
//
// Bundles every non-clock/reset signal of conv_window_ctrl:
//   frame request : width, height, start, abort
//   pixel stream  : in_valid, in_ready, (out_ready when
//                   CONV_WIN_CTRL_BACKPRESSURE_EN is defined)
//   generator     : fifo_reset_n, fifo_width, fifo_read
//   window marks  : win_valid, win_col, win_row, sof, eof
//   status        : busy, frame_done, cfg_err
//
// Modports:
//   slave  - the controller itself (consumes requests, drives status/marks)
//   master - the surrounding system / testbench
// ---------------------------------------------------------------------------
interface conv_window_ctrl_if;
  logic [15:0] width;
  logic [15:0] height;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
`ifdef CONV_WIN_CTRL_BACKPRESSURE_EN
  logic        out_ready;
`endif
  logic        fifo_reset_n;
  logic [15:0] fifo_width;
  logic        fifo_read;
  logic        win_valid;
  logic [15:0] win_col;
  logic [15:0] win_row;
  logic        sof;
  logic        eof;
  logic        busy;
  logic        frame_done;
  logic        cfg_err;

  modport slave (
    input  width, height, start, abort, in_valid,
`ifdef CONV_WIN_CTRL_BACKPRESSURE_EN
    input  out_ready,
`endif
    output in_ready, fifo_reset_n, fifo_width, fifo_read,
    output win_valid, win_col, win_row, sof, eof,
    output busy, frame_done, cfg_err
  );

  modport master (
    output width, height, start, abort, in_valid,
`ifdef CONV_WIN_CTRL_BACKPRESSURE_EN
    output out_ready,
`endif
    input  in_ready, fifo_reset_n, fifo_width, fifo_read,
    input  win_valid, win_col, win_row, sof, eof,
    input  busy, frame_done, cfg_err
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// ---------------------------------------------------------------------------
// conv_window_ctrl
//
// Sequencing controller for a KxK line-buffer window generator with a
// read/width/reset_n interface. It validates and latches the frame
// dimensions, holds the generator in reset for one cycle while it loads its
// size register, gates the pixel stream into it, tracks column/row of every
// accepted pixel and marks the windows that lie fully inside the image.
//
// Ports:
//   clock   - single clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - conv_window_ctrl_if.slave (request, stream, generator, marks)
//
// Parameters:
//   K         - kernel size
//   MAX_WIDTH - largest accepted width (generator MEMORY_SIZE)
//
// Optional feature macro: CONV_WIN_CTRL_BACKPRESSURE_EN
//   defined   - bus.out_ready gates acceptance and holds the window outputs
//   undefined - in_ready is high for the whole RUN state
// ---------------------------------------------------------------------------
module conv_window_ctrl #(
  parameter int K         = 3,
  parameter int MAX_WIDTH = 4096
) (
  input logic               clock,
  input logic               reset_n,
  conv_window_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [15:0] K_W   = 16'(K);
  localparam logic [15:0] K_M1  = 16'(K - 1);
  localparam logic [15:0] MAX_W = 16'(MAX_WIDTH);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [15:0] width_q;
  logic [15:0] height_q;
  logic [15:0] col;
  logic [15:0] row;
  logic        out_ok;
  logic        dims_ok;
  logic        start_idle;
  logic        accept;
  logic        qualify;
  logic        last_pixel;

  logic        win_valid_q;
  logic [15:0] win_col_q;
  logic [15:0] win_row_q;
  logic        sof_q;
  logic        eof_q;
  logic        cfg_err_q;

`ifdef CONV_WIN_CTRL_BACKPRESSURE_EN
  assign out_ok = bus.out_ready;
`else
  assign out_ok = 1'b1;
`endif

  // Dimension check uses the live inputs; everything after acceptance of
  // start works from the latched copies only.
  assign dims_ok    = (bus.width >= K_W) && (bus.width <= MAX_W) && (bus.height >= K_W);
  assign start_idle = (state == IDLE) && bus.start && !bus.abort;

  // Abort wins over a pixel offered in the same cycle.
  assign accept     = bus.in_valid && bus.in_ready && !bus.abort;
  assign qualify    = (col >= K_M1) && (row >= K_M1);
  assign last_pixel = (col == width_q - 16'd1) && (row == height_q - 16'd1);

  assign bus.in_ready     = (state == RUN) && out_ok;
  assign bus.fifo_read    = accept;
  // Generator is released only in RUN/DONE; IDLE and LOAD keep it in reset
  // so it samples width-K from a stable fifo_width.
  assign bus.fifo_reset_n = (state == RUN) || (state == DONE);
  assign bus.fifo_width   = width_q;
  assign bus.busy         = (state != IDLE);
  assign bus.frame_done   = (state == DONE);
  assign bus.cfg_err      = cfg_err_q;
  assign bus.win_valid    = win_valid_q;
  assign bus.win_col      = win_col_q;
  assign bus.win_row      = win_row_q;
  assign bus.sof          = sof_q;
  assign bus.eof          = eof_q;

  always_comb begin
    // NOTE: default assignment first so every path drives state_next and no
    // latch is inferred.
    state_next = state;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start && dims_ok) state_next = LOAD;
        LOAD:    state_next = RUN;
        RUN:     if (accept && last_pixel) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame configuration and pixel position counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      width_q   <= 16'd0;
      height_q  <= 16'd0;
      col       <= 16'd0;
      row       <= 16'd0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= start_idle && !dims_ok;
      if (start_idle && dims_ok) begin
        width_q  <= bus.width;
        height_q <= bus.height;
        col      <= 16'd0;
        row      <= 16'd0;
      end else if (accept) begin
        if (col == width_q - 16'd1) begin
          col <= 16'd0;
          row <= row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end
    end
  end

  // Window marks, registered to line up with the generator's own registered
  // valid. Held while downstream stalls; cleared by abort.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      win_valid_q <= 1'b0;
      win_col_q   <= 16'd0;
      win_row_q   <= 16'd0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else if (bus.abort) begin
      win_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else if (out_ok) begin
      win_valid_q <= accept && qualify;
      sof_q       <= accept && qualify && (col == K_M1) && (row == K_M1);
      eof_q       <= accept && qualify && last_pixel;
      if (accept && qualify) begin
        win_col_q <= col;
        win_row_q <= row;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_window_ctrl
//
// Scoreboard bench for conv_window_ctrl. The stimulus side computes, from
// the frame size and the number of pixels it intends to deliver, the list of
// interior windows (column/row/sof/eof) and queues them; an independent
// monitor pops one entry for every window the DUT presents.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_window_ctrl;
  localparam int K = 3;

  logic clock;
  logic reset_n;

  conv_window_ctrl_if bus();

  conv_window_ctrl #(.K(K), .MAX_WIDTH(4096)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic        sof;
    logic        eof;
  } win_t;

  win_t exp_q[$];
  win_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   frame_done_cnt = 0;
  int   cfg_err_cnt = 0;
  int   n;
  logic win_take;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef CONV_WIN_CTRL_BACKPRESSURE_EN
  assign win_take = bus.win_valid && bus.out_ready;
`else
  assign win_take = bus.win_valid;
`endif

  // Monitor: samples mid-cycle, away from the rising edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (win_take) begin
        if (exp_q.size() == 0) begin
          check("win_unexpected", {16'(bus.win_row), 16'(bus.win_col)}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("win_col", bus.win_col, mon_e.col);
          check("win_row", bus.win_row, mon_e.row);
          check("win_sof", bus.sof, mon_e.sof);
          check("win_eof", bus.eof, mon_e.eof);
        end
      end
      if (bus.frame_done) begin
        frame_done_cnt++;
        check("done_with_eof", bus.win_valid && bus.eof, 1);
      end
      if (bus.cfg_err) cfg_err_cnt++;
      check("fifo_read_is_accept", bus.fifo_read, bus.in_valid && bus.in_ready && !bus.abort);
    end
  end

  // Reference: pixels arrive in raster order, pixel i sits at (i%w, i/w).
  task automatic push_expected(input int w, input int h, input int pixels);
    win_t e;
    for (int i = 0; i < pixels; i++) begin
      int c = i % w;
      int r = i / w;
      if (c >= K - 1 && r >= K - 1) begin
        e.col = 16'(c);
        e.row = 16'(r);
        e.sof = (c == K - 1) && (r == K - 1);
        e.eof = (c == w - 1) && (r == h - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_fifo_reset_n"}, bus.fifo_reset_n, 0);
    check({tag, "_fifo_width"}, bus.fifo_width, 0);
    check({tag, "_fifo_read"}, bus.fifo_read, 0);
    check({tag, "_win_valid"}, bus.win_valid, 0);
    check({tag, "_win_col"}, bus.win_col, 0);
    check({tag, "_win_row"}, bus.win_row, 0);
    check({tag, "_sof_eof"}, {bus.sof, bus.eof}, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_cfg_err"}, bus.cfg_err, 0);
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 of the first RUN cycle.
  task automatic start_frame(input int w, input int h);
    bus.width  = 16'(w);
    bus.height = 16'(h);
    bus.start  = 1'b1;
    @(posedge clock); #1;
    check("load_in_ready", bus.in_ready, 0);
    check("load_fifo_reset_n", bus.fifo_reset_n, 0);
    check("load_fifo_width", bus.fifo_width, w);
    check("load_busy", bus.busy, 1);
    // A start in LOAD with other dimensions must be ignored.
    bus.width = 16'(w + 1);
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.width = 16'($urandom);
    check("run_in_ready", bus.in_ready, 1);
    check("run_fifo_reset_n", bus.fifo_reset_n, 1);
    check("run_fifo_width", bus.fifo_width, w);
  endtask

  task automatic run_pixels(input int pct, input int stop_at, output int got);
    int  cyc;
    logic acc;
    cyc = 0;
    got = 0;
    while (got < stop_at && cyc < 2000) begin
      bus.in_valid = ($urandom_range(99) < pct);
      acc = bus.in_valid && bus.in_ready;
      check("run_in_ready_hi", bus.in_ready, 1);
      @(posedge clock); #1;
      if (acc) got++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (got < stop_at) check("pixel_timeout", got, stop_at);
  endtask

  // Called at posedge+1 of the DONE cycle.
  task automatic finish_frame();
    int fd0;
    fd0 = frame_done_cnt;
    check("done_frame_done", bus.frame_done, 1);
    check("done_in_ready", bus.in_ready, 0);
    check("done_eof", bus.eof, 1);
    bus.start = 1'b1;          // back-to-back start in DONE is ignored
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("idle_busy", bus.busy, 0);
    check("idle_fifo_reset_n", bus.fifo_reset_n, 0);
    check("idle_no_cfg_err", bus.cfg_err, 0);
    check("frame_done_count", frame_done_cnt, fd0 + 1);
    check("sb_drained", exp_q.size(), 0);
  endtask

  task automatic full_frame(input int w, input int h, input int pct);
    int got;
    start_frame(w, h);
    push_expected(w, h, w * h);
    run_pixels(pct, w * h, got);
    finish_frame();
  endtask

  int c0;
  int fd0;

  initial begin
    reset_n      = 1'b0;
    bus.width    = 16'd0;
    bus.height   = 16'd0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
`ifdef CONV_WIN_CTRL_BACKPRESSURE_EN
    bus.out_ready = 1'b1;
`endif
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_reset_busy", bus.busy, 0);

    // Nominal 8x4 frame, source always valid.
    full_frame(8, 4, 100);

    // Bad dimensions: each request pulses cfg_err once and stays idle.
    c0 = cfg_err_cnt;
    for (int i = 0; i < 3; i++) begin
      bus.width  = (i == 0) ? 16'd2 : (i == 1) ? 16'd5000 : 16'd8;
      bus.height = (i == 2) ? 16'd1 : 16'd4;
      bus.start  = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
      check("bad_cfg_err_pulse", bus.cfg_err, 1);
      check("bad_busy", bus.busy, 0);
      check("bad_fifo_reset_n", bus.fifo_reset_n, 0);
      @(posedge clock); #1;
      check("bad_cfg_err_low", bus.cfg_err, 0);
    end
    check("bad_cfg_err_count", cfg_err_cnt - c0, 3);

    // Abort together with a (bad) start in IDLE: abort wins, no cfg_err.
    bus.width = 16'd2; bus.height = 16'd4; bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_idle_busy", bus.busy, 0);
    check("abort_idle_cfg_err", bus.cfg_err, 0);

    // Stalled source, 8x4.
    full_frame(8, 4, 50);

    // Abort after 17 acceptances, then a clean frame.
    start_frame(8, 4);
    push_expected(8, 4, 17);
    run_pixels(100, 17, n);
    fd0 = frame_done_cnt;
    bus.abort = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    check("abort_blocks_read", bus.fifo_read, 0);
    @(posedge clock); #1;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_fifo_reset_n", bus.fifo_reset_n, 0);
    check("abort_in_ready", bus.in_ready, 0);
    repeat (3) @(posedge clock);
    #1;
    check("abort_no_frame_done", frame_done_cnt, fd0);
    check("abort_sb_drained", exp_q.size(), 0);
    full_frame(8, 4, 100);

    // Asynchronous reset at row 2, col 5 (21 pixels accepted).
    start_frame(8, 4);
    push_expected(8, 4, 21);
    run_pixels(100, 21, n);
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("areset");
    bus.width = 16'd8; bus.height = 16'd4; bus.start = 1'b1;
    @(posedge clock); #1;
    check("areset_start_ignored", bus.busy, 0);
    bus.start = 1'b0;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("areset_idle", bus.busy, 0);
    check("areset_sb_drained", exp_q.size(), 0);

    // Minimum frame: one window carrying both sof and eof.
    full_frame(3, 3, 100);

    // Random frames.
    for (int f = 0; f < 2; f++) begin
      full_frame(int'($urandom_range(12, 3)), int'($urandom_range(6, 3)),
                 int'($urandom_range(100, 30)));
    end

`ifdef CONV_WIN_CTRL_BACKPRESSURE_EN
    // Downstream stall for 5 cycles while window (3,2) is presented.
    start_frame(8, 4);
    push_expected(8, 4, 32);
    run_pixels(100, 20, n);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_hold_valid", bus.win_valid, 1);
      check("bp_hold_col", bus.win_col, 3);
      check("bp_hold_row", bus.win_row, 2);
      @(posedge clock); #1;
    end
    bus.out_ready = 1'b1;
    run_pixels(100, 12, n);
    finish_frame();
    full_frame(3, 3, 100);
`endif

    repeat (2) @(posedge clock);
    #1;
    check("final_sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
